// File: rtl/fetch_unit_if.sv
`timescale 1ns/1ps
// fetch_unit_if
// Purpose: bundles the instruction-memory request channel, the redirect
//          input and the IF/ID output handshake of the fetch unit.
// Signals:
//   imem_req    fetch unit -> memory   request valid
//   imem_addr   fetch unit -> memory   word-aligned fetch address
//   imem_ack    memory -> fetch unit   request accepted, imem_rdata valid
//   imem_rdata  memory -> fetch unit   instruction word
//   redirect    core -> fetch unit     branch/jump taken
//   redirect_pc core -> fetch unit     new fetch address (bits [1:0] ignored)
//   out_valid   fetch unit -> IF/ID    out_pc/out_inst hold an instruction
//   out_pc      fetch unit -> IF/ID    address of the presented instruction
//   out_inst    fetch unit -> IF/ID    presented instruction
//   out_ready   IF/ID -> fetch unit    load enable of the IF/ID register
// Modports: master = fetch unit side, slave = memory/core side.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;
  logic            out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_inst,
    input  imem_ack, imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_inst,
    output imem_ack, imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit
// Purpose: instruction fetch stage. Issues word-aligned fetches to
//          instruction memory, buffers returned words in a small FIFO and
//          presents them to the IF/ID register. A redirect flushes the
//          buffer, reloads the fetch PC and discards any in-flight fetch.
// Configuration: define FETCH_SKID_EN for a 2-entry output buffer (one
//          instruction per cycle); otherwise the buffer holds 1 entry.
// Ports:
//   clk   clock, rising-edge
//   rst   asynchronous active-low reset
//   bus   fetch_unit_if.master (imem request channel, redirect, output)
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no memory request outstanding
// REQ    | request outstanding; acked data goes into the output buffer
// DROP   | request outstanding; its data is discarded after a redirect
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

`ifdef FETCH_SKID_EN
  localparam logic [1:0] CAP  = 2'd2;
  localparam logic       SKID = 1'b1;
`else
  localparam logic [1:0] CAP  = 2'd1;
  localparam logic       SKID = 1'b0;
`endif

  localparam logic [XLEN-1:0] ALIGN_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [1:0]      count_q, count_after;
  logic            head_q, tail_q;
  logic [XLEN-1:0] ent_pc   [2];
  logic [XLEN-1:0] ent_inst [2];
  logic            acc, push, pop, slot_free;

  // Pointers only move in the 2-entry build; with one entry they stay at 0.
  function automatic logic ptr_inc(input logic p);
    return ~p & SKID;
  endfunction

  always_comb begin
    acc         = (state_q != S_IDLE) && bus.imem_ack;
    push        = (state_q == S_REQ) && bus.imem_ack && !bus.redirect;
    pop         = (count_q != 2'd0) && bus.out_ready && !bus.redirect;
    count_after = count_q + {1'b0, push} - {1'b0, pop};
    // A new request may only be issued if its data is guaranteed a slot.
    slot_free   = (count_after < CAP);
    state_d     = state_q;
    pc_d        = pc_q;

    case (state_q)
      S_IDLE: begin
        if (!bus.redirect && slot_free) state_d = S_REQ;
      end
      S_REQ: begin
        if (bus.redirect) begin
          state_d = acc ? S_IDLE : S_DROP;
        end else if (acc) begin
          pc_d    = pc_q + XLEN'(4);
          state_d = slot_free ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (acc) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (bus.redirect) pc_d = bus.redirect_pc & ALIGN_MASK;

    // The address register only follows the PC when a request starts, so
    // it stays frozen during DROP even though the PC was already reloaded.
    addr_d = (state_d == S_REQ) ? pc_d : addr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC & ALIGN_MASK;
      addr_q      <= RESET_PC & ALIGN_MASK;
      count_q     <= 2'd0;
      head_q      <= 1'b0;
      tail_q      <= 1'b0;
      ent_pc[0]   <= '0;
      ent_pc[1]   <= '0;
      ent_inst[0] <= '0;
      ent_inst[1] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      if (bus.redirect) begin
        count_q <= 2'd0;
        head_q  <= 1'b0;
        tail_q  <= 1'b0;
      end else begin
        count_q <= count_after;
        if (push) begin
          ent_pc[tail_q]   <= pc_q;
          ent_inst[tail_q] <= bus.imem_rdata;
          tail_q           <= ptr_inc(tail_q);
        end
        if (pop) head_q <= ptr_inc(head_q);
      end
    end
  end

  assign bus.imem_req  = (state_q != S_IDLE);
  assign bus.imem_addr = addr_q;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_pc    = ent_pc[head_q];
  assign bus.out_inst  = ent_inst[head_q];

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
// tb_fetch_unit
// Purpose: self-checking bench for fetch_unit. Directed scenarios followed
//          by random traffic, all compared against a transaction-level model
//          (expected fetch address, outstanding/discard flags and a queue of
//          instructions awaiting transfer).
module tb_fetch_unit;
  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fetch_unit_if #(.XLEN(XLEN)) bus();

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  ent_t        q[$];
  logic [31:0] m_pc;
  logic [31:0] m_addr;
  bit          m_out;
  bit          m_drop;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc   = RESET_PC;
    m_addr = RESET_PC;
    m_out  = 1'b0;
    m_drop = 1'b0;
  endtask

  task automatic check_outputs();
    chk("imem_req", 64'(bus.imem_req), 64'(m_out));
    if (m_out) begin
      chk("imem_addr", 64'(bus.imem_addr), 64'(m_addr));
      chk("addr_align", 64'(bus.imem_addr[1:0]), 64'd0);
    end
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_pc", 64'(bus.out_pc), 64'(q[0].pc));
      chk("out_inst", 64'(bus.out_inst), 64'(q[0].inst));
    end
  endtask

  // One clock of the reference behaviour, given the inputs applied in it.
  task automatic model_update(input bit ack, input logic [31:0] rd, input bit rdy,
                              input bit rdr, input logic [31:0] rpc);
    bit   acc;
    bit   was_idle;
    bit   refetch;
    ent_t e;
    acc      = m_out && ack;
    was_idle = !m_out;
    refetch  = 1'b0;
    if (rdr) begin
      q.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (acc) begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else if (m_out) begin
        m_drop = 1'b1;
      end
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (acc) begin
        if (!m_drop) begin
          e.pc   = m_addr;
          e.inst = rd;
          q.push_back(e);
          m_pc    = m_addr + 32'd4;
          refetch = 1'b1;
        end
        m_out  = 1'b0;
        m_drop = 1'b0;
      end
      if ((was_idle || refetch) && q.size() < CAP) begin
        m_out  = 1'b1;
        m_addr = m_pc;
      end
    end
  endtask

  // Called at a falling edge: check, drive, clock, update model.
  task automatic step(input bit ack, input logic [31:0] rd, input bit rdy,
                      input bit rdr, input logic [31:0] rpc);
    check_outputs();
    bus.imem_ack    = ack;
    bus.imem_rdata  = rd;
    bus.out_ready   = rdy;
    bus.redirect    = rdr;
    bus.redirect_pc = rpc;
    @(posedge clk);
    model_update(ack, rd, rdy, rdr, rpc);
    @(negedge clk);
  endtask

  task automatic sync_reset();
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = '0;
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    model_reset();

    // Reset values
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req", 64'(bus.imem_req), 64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_pc", 64'(bus.out_pc), 64'd0);
    chk("rst_out_inst", 64'(bus.out_inst), 64'd0);
    rst = 1'b1;

    // First request follows the first edge out of reset
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("first_req", 64'(bus.imem_req), 64'd1);
    chk("first_addr", 64'(bus.imem_addr), 64'(RESET_PC));

    // Streaming with ack every cycle and ready high
    for (int i = 0; i < 10; i++) step(1'b1, $urandom, 1'b1, 1'b0, 32'h0);

    // Back-pressure: buffer fills, request stops, then in-order drain
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    chk("full_req_low", 64'(bus.imem_req), 64'd0);
    chk("full_valid", 64'(bus.out_valid), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

    // Delayed ack holds the address
    sync_reset();
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'hA000_0000, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("hold_addr_0", 64'(bus.imem_addr), 64'h4);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("hold_addr_1", 64'(bus.imem_addr), 64'h4);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("hold_addr_2", 64'(bus.imem_addr), 64'h4);
    step(1'b1, 32'hA000_0004, 1'b1, 1'b0, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("advance_req", 64'(bus.imem_req), 64'd1);
    chk("advance_addr", 64'(bus.imem_addr), 64'h8);

    // Redirect with a request outstanding: its data is dropped
    step(1'b0, 32'h0, 1'b1, 1'b1, 32'h103);
    chk("flush_valid", 64'(bus.out_valid), 64'd0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    chk("drop_valid", 64'(bus.out_valid), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("redir_req", 64'(bus.imem_req), 64'd1);
    chk("redir_addr", 64'(bus.imem_addr), 64'h100);

    // Redirect, ack and transfer in one cycle
    step(1'b1, 32'hB000_0100, 1'b1, 1'b0, 32'h0);
    step(1'b1, 32'hBAD0_0000, 1'b1, 1'b1, 32'h200);
    chk("triple_valid", 64'(bus.out_valid), 64'd0);
    chk("triple_req", 64'(bus.imem_req), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("triple_addr", 64'(bus.imem_addr), 64'h200);

    // Asynchronous reset between edges, mid-request
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    #2 rst = 1'b0;
    #1;
    chk("async_req", 64'(bus.imem_req), 64'd0);
    chk("async_valid", 64'(bus.out_valid), 64'd0);
    chk("async_out_pc", 64'(bus.out_pc), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("restart_addr", 64'(bus.imem_addr), 64'(RESET_PC));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom);
    end
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 1) != 0, $urandom, $urandom_range(0, 4) == 0,
           $urandom_range(0, 40) == 0, $urandom);
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, instruction and address width in bits.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  XLEN  fetch address; bits [1:0] always 0.
REQ-007 imem_ack  input  1  memory accepted the request; imem_rdata is valid in the same cycle.
REQ-008 imem_rdata  input  XLEN  fetched instruction word.
REQ-009 redirect  input  1  branch/jump taken; discard the in-flight stream.
REQ-010 redirect_pc  input  XLEN  new fetch address; bits [1:0] ignored and treated as 0.
REQ-011 out_valid  output  1  out_pc/out_inst hold a fetched instruction for the IF/ID register.
REQ-012 out_pc  output  XLEN  address of the presented instruction.
REQ-013 out_inst  output  XLEN  presented instruction.
REQ-014 out_ready  input  1  IF/ID register load enable; a transfer occurs when out_valid and out_ready are both high.

Function
REQ-015 Fetch PC register: advances by 4 on each accepted ack (imem_req and imem_ack high, no redirect); wraps modulo 2^XLEN.
REQ-016 FSM states: IDLE (no request outstanding), REQ (request outstanding), DROP (request outstanding whose data is discarded).
REQ-017 IDLE->REQ when the buffer has a free slot and redirect is low; imem_req high in REQ and DROP only.
REQ-018 imem_addr is the fetch PC and stays stable while imem_req is high and imem_ack is low.
REQ-019 REQ->IDLE on ack; REQ->REQ on ack when a slot remains free after the write (back-to-back, one fetch per cycle).
REQ-020 Acked data is written to the output buffer; the entry becomes visible on out_valid one cycle after the ack edge (latency 1).
REQ-021 Output buffer is FIFO ordered; an entry is popped on each transfer; push and pop in the same cycle leave occupancy unchanged.
REQ-022 No request is issued when occupancy plus outstanding requests equals capacity; overflow is impossible.
REQ-023 On redirect: flush the buffer (out_valid low next cycle) and load the fetch PC from redirect_pc; redirect has priority over a same-cycle ack or transfer.
REQ-024 Redirect in REQ without same-cycle ack -> DROP; a redirect accompanied by a same-cycle ack discards that data and -> IDLE.
REQ-025 DROP: the next ack's data is discarded, the PC is unchanged, and the FSM -> IDLE; a further redirect in DROP only reloads the PC.
REQ-026 out_pc/out_inst are held stable while out_valid is high and out_ready is low.

Reset
REQ-027 rst low asynchronously forces FSM=IDLE, PC=RESET_PC, buffer empty, imem_req=0, out_valid=0, out_pc=0, out_inst=0.
REQ-028 First imem_req is asserted in the cycle after the first rising edge with rst high.
REQ-029 Reset asserted mid-request abandons that request; the first post-reset request uses RESET_PC.

Configuration
REQ-030 Macro FETCH_SKID_EN defined: output buffer capacity is 2, sustaining one instruction per cycle with out_ready held high.
REQ-031 FETCH_SKID_EN undefined: capacity is 1; a new request is issued only when the buffer is empty or a transfer is occurring, giving at most one instruction every 2 cycles.

Verification
REQ-032 Reset release, ack every cycle, out_ready=1 -> out_pc sequence 0x0,0x4,0x8,... with out_inst matching imem_rdata; one per cycle with FETCH_SKID_EN defined.
REQ-033 out_ready=0 for 5 cycles -> at most capacity entries are buffered, imem_req is low once full, and out_pc/out_inst are stable; out_ready=1 -> in-order drain with no loss.
REQ-034 Memory delays ack by 3 cycles -> imem_addr is held at 0x4 for all 3 cycles; a single advance to 0x8.
REQ-035 redirect with redirect_pc=0x103 while a request is outstanding -> the following ack's data is dropped, the next imem_addr is 0x100, and out_valid is low during the flush.
REQ-036 redirect, ack and transfer in the same cycle -> the ack data is discarded, the buffer is empty, and the PC is set to redirect_pc.
REQ-037 rst pulsed low mid-request between clock edges -> immediate imem_req=0 and out_valid=0; restart at RESET_PC.
